// File: rtl/ultra_wide_bus_serializer.sv
// Captures one wide frame over valid/ready and streams it out as narrow beats
// with beat index and last flag; counts completed frames modulo 2^16.
module ultra_wide_bus_serializer #(
   parameter  int BUS_W     = 1024,
   parameter  int BEAT_W    = 32,
   parameter  int MSB_FIRST = 0,
   localparam int NUM_BEATS = BUS_W / BEAT_W,
   localparam int IDX_W     = $clog2(NUM_BEATS)
) (
   input  logic              main_clk_100mhz,
   input  logic              reset,
   input  logic [BUS_W-1:0]  in_bus,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BEAT_W-1:0] out_beat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy,
   output logic [15:0]       frame_count
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [BUS_W-1:0]  frame_q, frame_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [15:0]       count_q, count_d;
   logic              send_s, last_s, hs_s, accept_s;
   logic [BEAT_W-1:0] beat_s;

   assign send_s   = (state_q == ST_SEND);
   assign last_s   = (index_q == IDX_W'(NUM_BEATS - 1));
   assign hs_s     = send_s & out_ready;
   // The out_ready -> in_ready path lets a new frame be taken on the last beat.
   assign in_ready = ~reset & (~send_s | (hs_s & last_s));
   assign accept_s = in_valid & in_ready;

   // Next-state, frame capture, beat index and frame counter
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      index_d = index_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               frame_d = in_bus;
               index_d = {IDX_W{1'b0}};
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (hs_s && last_s) begin
               count_d = count_q + 16'd1;
               index_d = {IDX_W{1'b0}};
               if (accept_s) begin
                  frame_d = in_bus;
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (hs_s) begin
               index_d = index_q + IDX_W'(1);
            end else begin
               index_d = index_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            index_d = {IDX_W{1'b0}};
         end
      endcase
   end

   // Beat selection from the held frame; zero whenever no beat is offered
   always_comb begin
      beat_s = {BEAT_W{1'b0}};
      if (!send_s) begin
         beat_s = {BEAT_W{1'b0}};
      end else if (MSB_FIRST != 0) begin
         beat_s = frame_q[(NUM_BEATS - 1 - int'(index_q)) * BEAT_W +: BEAT_W];
      end else begin
         beat_s = frame_q[int'(index_q) * BEAT_W +: BEAT_W];
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge main_clk_100mhz) begin
      if (reset) begin
         state_q <= ST_IDLE;
         frame_q <= {BUS_W{1'b0}};
         index_q <= {IDX_W{1'b0}};
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         index_q <= index_d;
         count_q <= count_d;
      end
   end

   assign out_valid   = send_s;
   assign busy        = send_s;
   assign out_last    = send_s & last_s;
   assign out_index   = index_q;
   assign out_beat    = beat_s;
   assign frame_count = count_q;

endmodule

// File: tb/tb_ultra_wide_bus_serializer.sv
// Randomised bench: an LSB-first and an MSB-first serializer share stimulus and
// are compared against a queue-of-expected-beats reference model.
module tb_ultra_wide_bus_serializer;

   localparam int NB = 32;

   typedef struct {
      logic [31:0] bl;
      logic [31:0] bm;
      logic [4:0]  idx;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1023:0] in_bus;
   logic          in_valid;
   logic          out_ready;
   logic          in_ready_l, out_valid_l, out_last_l, busy_l;
   logic          in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [31:0]   out_beat_l, out_beat_m;
   logic [4:0]    out_index_l, out_index_m;
   logic [15:0]   frame_count_l, frame_count_m;

   beat_t       q[$];
   logic [15:0] exp_count;
   int          vectors = 0;
   int          errors  = 0;
   logic        obs_ir, obs_hs;

   always #5 clk = ~clk;

   ultra_wide_bus_serializer #(.BUS_W(1024), .BEAT_W(32), .MSB_FIRST(0)) dut (
      .main_clk_100mhz(clk), .reset(reset), .in_bus(in_bus), .in_valid(in_valid),
      .in_ready(in_ready_l), .out_beat(out_beat_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .out_last(out_last_l), .out_index(out_index_l),
      .busy(busy_l), .frame_count(frame_count_l));

   ultra_wide_bus_serializer #(.BUS_W(1024), .BEAT_W(32), .MSB_FIRST(1)) dut_m (
      .main_clk_100mhz(clk), .reset(reset), .in_bus(in_bus), .in_valid(in_valid),
      .in_ready(in_ready_m), .out_beat(out_beat_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .out_last(out_last_m), .out_index(out_index_m),
      .busy(busy_m), .frame_count(frame_count_m));

   function automatic logic [1023:0] rand_frame();
      logic [1023:0] f;
      for (int i = 0; i < NB; i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   // One clock cycle: drive at the falling edge, compare against the model, advance the model.
   task automatic step(input logic rst, input logic iv, input logic [1023:0] f, input logic ordy);
      logic        ev, el, eir;
      logic [31:0] ebl, ebm;
      logic [4:0]  eidx;
      beat_t       e;
      reset = rst; in_valid = iv; in_bus = f; out_ready = ordy;
      #1;
      ev   = (q.size() > 0);
      ebl  = ev ? q[0].bl : 32'd0;
      ebm  = ev ? q[0].bm : 32'd0;
      eidx = ev ? q[0].idx : 5'd0;
      el   = ev && (eidx == 5'(NB - 1));
      eir  = !rst && (q.size() == 0 || (q.size() == 1 && ordy));
      obs_ir = in_ready_l;
      obs_hs = out_valid_l & ordy;
      vectors += 12;
      if (out_valid_l !== ev || out_valid_m !== ev) begin errors++; $display("FAIL out_valid got %b/%b want %b", out_valid_l, out_valid_m, ev); end
      if (busy_l !== ev || busy_m !== ev) begin errors++; $display("FAIL busy got %b/%b want %b", busy_l, busy_m, ev); end
      if (in_ready_l !== eir) begin errors++; $display("FAIL in_ready got %b want %b", in_ready_l, eir); end
      if (in_ready_m !== eir) begin errors++; $display("FAIL in_ready_msb got %b want %b", in_ready_m, eir); end
      if (out_beat_l !== ebl) begin errors++; $display("FAIL out_beat got %h want %h", out_beat_l, ebl); end
      if (out_beat_m !== ebm) begin errors++; $display("FAIL out_beat_msb got %h want %h", out_beat_m, ebm); end
      if (out_index_l !== eidx) begin errors++; $display("FAIL out_index got %0d want %0d", out_index_l, eidx); end
      if (out_index_m !== eidx) begin errors++; $display("FAIL out_index_msb got %0d want %0d", out_index_m, eidx); end
      if (out_last_l !== el) begin errors++; $display("FAIL out_last got %b want %b", out_last_l, el); end
      if (out_last_m !== el) begin errors++; $display("FAIL out_last_msb got %b want %b", out_last_m, el); end
      if (frame_count_l !== exp_count) begin errors++; $display("FAIL frame_count got %h want %h", frame_count_l, exp_count); end
      if (frame_count_m !== exp_count) begin errors++; $display("FAIL frame_count_msb got %h want %h", frame_count_m, exp_count); end
      @(posedge clk);
      if (rst) begin
         q.delete();
         exp_count = 16'd0;
      end else begin
         if (ev && ordy) begin
            if (el) exp_count = exp_count + 16'd1;
            void'(q.pop_front());
         end
         if (iv && eir) begin
            for (int i = 0; i < NB; i++) begin
               e.bl = f[i*32 +: 32]; e.bm = f[(NB-1-i)*32 +: 32]; e.idx = 5'(i);
               q.push_back(e);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, '0, 1'b1);
      vectors++;
      if (out_valid_l !== 1'b0 || frame_count_l !== 16'd0 || in_ready_l !== 1'b0) begin
         errors++; $display("FAIL reset_state got v=%b cnt=%h ir=%b want 0/0/0", out_valid_l, frame_count_l, in_ready_l);
      end
      step(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_basic();
      logic [1023:0] f;
      logic [15:0]   c0;
      for (int i = 0; i < NB; i++) f[i*32 +: 32] = 32'(i);
      c0 = frame_count_l;
      step(1'b0, 1'b1, f, 1'b1);
      for (int i = 0; i < NB; i++) begin
         vectors++;
         if (out_beat_l !== 32'(i) || out_beat_m !== 32'(NB-1-i) || out_index_m !== 5'(i) || out_last_l !== (i == NB-1)) begin
            errors++; $display("FAIL basic_beat%0d got %h/%h idx=%0d last=%b", i, out_beat_l, out_beat_m, out_index_m, out_last_l);
         end
         step(1'b0, 1'b0, '0, 1'b1);
      end
      vectors++;
      if (frame_count_l !== c0 + 16'd1) begin errors++; $display("FAIL basic_count got %h want %h", frame_count_l, c0 + 16'd1); end
   endtask

   task automatic test_stall();
      logic [1023:0] f;
      int            cyc;
      logic [15:0]   c0;
      for (int i = 0; i < NB; i++) f[i*32 +: 32] = 32'(i);
      c0 = frame_count_l;
      step(1'b0, 1'b1, f, 1'b1);
      cyc = 0;
      for (int k = 0; k < 60 && out_valid_l; k++) begin
         if (k >= 5 && k < 8) begin
            vectors++;
            if (out_beat_l !== 32'd5 || out_index_l !== 5'd5) begin
               errors++; $display("FAIL stall_hold got beat=%h idx=%0d want 5/5", out_beat_l, out_index_l);
            end
         end
         step(1'b0, 1'b0, '0, !(k >= 5 && k < 8));
         cyc++;
      end
      vectors++;
      if (cyc !== 35 || frame_count_l !== c0 + 16'd1) begin
         errors++; $display("FAIL stall_len got %0d cycles cnt=%h want 35 cnt=%h", cyc, frame_count_l, c0 + 16'd1);
      end
   endtask

   task automatic test_back_to_back();
      logic [1023:0] a, b;
      int            pulses, hs, pulse_at;
      a = rand_frame(); b = rand_frame();
      step(1'b0, 1'b1, a, 1'b1);
      pulses = 0; hs = 0; pulse_at = -1;
      for (int k = 0; k < 2*NB; k++) begin
         step(1'b0, k < NB, b, 1'b1);
         if (obs_hs) hs++;
         if (k < NB && obs_ir) begin pulses++; pulse_at = k; end
      end
      vectors++;
      if (hs !== 2*NB || pulses !== 1 || pulse_at !== NB-1 || out_valid_l !== 1'b0) begin
         errors++; $display("FAIL b2b got hs=%0d pulses=%0d at=%0d want 64/1/31", hs, pulses, pulse_at);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++)
         step(1'b0, ($urandom_range(0, 2) == 0), rand_frame(), ($urandom_range(0, 3) != 0));
      while (q.size() > 0) step(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, rand_frame(), 1'b1);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, rand_frame(), 1'b1);
      vectors++;
      if (out_valid_l || out_beat_l !== 32'd0 || out_index_l !== 5'd0 || out_last_l || busy_l || in_ready_l || frame_count_l !== 16'd0) begin
         errors++; $display("FAIL reset_mid got v=%b beat=%h idx=%0d ir=%b cnt=%h", out_valid_l, out_beat_l, out_index_l, in_ready_l, frame_count_l);
      end
      step(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_wrap();
      force dut.count_q = 16'hFFFF;
      force dut_m.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      release dut_m.count_q;
      exp_count = 16'hFFFF;
      step(1'b0, 1'b1, rand_frame(), 1'b1);
      while (q.size() > 0) step(1'b0, 1'b0, '0, 1'b1);
      vectors++;
      if (frame_count_l !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", frame_count_l); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0;
      exp_count = 16'd0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
